// File: rtl/gpu_raster_pkg.sv
// Shared types and constants for the triangle edge rasteriser.
//   LB_DIM         : outline bitmap edge length in pixels
//   COORD_W        : vertex coordinate width
//   LOC_W          : width of the signed bbox-local coordinates and error term
//   raster_state_t : rasteriser FSM states
//   vertex_t       : one vertex, packed {y, x} to match the coordinate bus layout
//   unpack_coords  : extracts vertex 0/1/2 from the {y2,x2,y1,x1,y0,x0} bus
package gpu_raster_pkg;

  localparam int LB_DIM  = 64;
  localparam int COORD_W = 8;
  localparam int LOC_W   = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EDGE_INIT,
    STEP,
    DONE
  } raster_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } vertex_t;

  function automatic vertex_t unpack_coords(input logic [6*COORD_W-1:0] c,
                                            input logic [1:0]           idx);
    vertex_t v;
    case (idx)
      2'd0:    v = vertex_t'(c[2*COORD_W-1:0]);
      2'd1:    v = vertex_t'(c[4*COORD_W-1:2*COORD_W]);
      default: v = vertex_t'(c[6*COORD_W-1:4*COORD_W]);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Single-edge Bresenham walker, one pixel per clock.
//   clk      : clock
//   init_i   : load a new edge from (xa,ya) to (xb,yb); current point becomes (xa,ya)
//   step_i   : advance one pixel (no effect once the end point is reached)
//   xa_i..yb_i : signed local start/end coordinates
//   x_o, y_o : current point
//   at_end_o : current point equals the end point
// The registers here are pure datapath and are always (re)loaded by init_i
// before they are consumed, so they carry no reset.
module bresenham_stepper
  import gpu_raster_pkg::*;
(
  input  logic                    clk,
  input  logic                    init_i,
  input  logic                    step_i,
  input  logic signed [LOC_W-1:0] xa_i,
  input  logic signed [LOC_W-1:0] ya_i,
  input  logic signed [LOC_W-1:0] xb_i,
  input  logic signed [LOC_W-1:0] yb_i,
  output logic signed [LOC_W-1:0] x_o,
  output logic signed [LOC_W-1:0] y_o,
  output logic                    at_end_o
);

  localparam logic signed [LOC_W-1:0] ONE = LOC_W'(1);

  logic signed [LOC_W-1:0] x_q, y_q, xe_q, ye_q, err_q, dx_q, dy_q;
  logic                    sx_neg_q, sy_neg_q;

  logic signed [LOC_W-1:0] dx_d, dy_d, err_d, x_d, y_d;
  logic signed [LOC_W:0]   e2, dx_ext, dy_ext;
  logic                    move_x, move_y;

  always_comb begin
    dx_d   = (xb_i >= xa_i) ? (xb_i - xa_i) : (xa_i - xb_i);
    // dy is kept as the negated magnitude, as in the classic integer form
    dy_d   = (yb_i >= ya_i) ? (ya_i - yb_i) : (yb_i - ya_i);
    e2     = {err_q, 1'b0};
    dx_ext = {dx_q[LOC_W-1], dx_q};
    dy_ext = {dy_q[LOC_W-1], dy_q};
    move_x = (e2 >= dy_ext);
    move_y = (e2 <= dx_ext);
    // both tests use the error value from before this step
    err_d  = err_q + (move_x ? dy_q : '0) + (move_y ? dx_q : '0);
    x_d    = move_x ? (sx_neg_q ? x_q - ONE : x_q + ONE) : x_q;
    y_d    = move_y ? (sy_neg_q ? y_q - ONE : y_q + ONE) : y_q;
  end

  assign at_end_o = (x_q == xe_q) && (y_q == ye_q);
  assign x_o      = x_q;
  assign y_o      = y_q;

  always_ff @(posedge clk) begin
    if (init_i) begin
      x_q      <= xa_i;
      y_q      <= ya_i;
      xe_q     <= xb_i;
      ye_q     <= yb_i;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= dx_d + dy_d;
      sx_neg_q <= (xb_i < xa_i);
      sy_neg_q <= (yb_i < ya_i);
    end else if (step_i && !at_end_o) begin
      x_q   <= x_d;
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/edge_raster_block.sv
// Rasterises the three edges of a triangle into a 64x64 outline bitmap whose
// origin is the vertex bounding-box corner (xmin,ymin).
//   clk          : clock
//   n_rst        : asynchronous active-low reset
//   coordinates  : {y2,x2,y1,x1,y0,x0}, 8 bits each
//   raster_start : 1-clk pulse, accepted only when idle
//   busy         : raster in progress
//   raster_done  : 1-clk pulse when the bitmap is complete
//   clipped      : an edge pixel fell outside the bitmap window (valid with done)
//   line_buffer  : row r = [r*64 +: 64], column c = bit c of the row
//   pixel_count  : STEP cycles of the last raster, saturating at 255
// Optional feature macro: EDGE_PIXEL_COUNT_EN adds the pixel_count port/counter.
module edge_raster_block
  import gpu_raster_pkg::*;
(
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [6*COORD_W-1:0]       coordinates,
  input  logic                       raster_start,
  output logic                       busy,
  output logic                       raster_done,
  output logic                       clipped,
  output logic [LB_DIM*LB_DIM-1:0]   line_buffer
`ifdef EDGE_PIXEL_COUNT_EN
  ,
  output logic [7:0]                 pixel_count
`endif
);

  localparam int                      IDX_W  = $clog2(LB_DIM);
  localparam logic signed [LOC_W-1:0] LB_LIM = LOC_W'(LB_DIM);

  raster_state_t             state_q;
  logic                      busy_q, done_q, clip_q;
  logic [1:0]                edge_q;
  logic [LB_DIM*LB_DIM-1:0]  lb_q;
  logic [6*COORD_W-1:0]      coords_q;
  logic [COORD_W-1:0]        xmin_q, ymin_q;

  vertex_t                   v0, v1, v2, va, vb;
  logic signed [LOC_W-1:0]   xa_l, ya_l, xb_l, yb_l, cur_x, cur_y;
  logic                      at_end, in_win;
  logic [2*IDX_W-1:0]        pix_idx;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  always_comb begin
    v0 = unpack_coords(coords_q, 2'd0);
    v1 = unpack_coords(coords_q, 2'd1);
    v2 = unpack_coords(coords_q, 2'd2);
    case (edge_q)
      2'd0:    begin va = v0; vb = v1; end
      2'd1:    begin va = v1; vb = v2; end
      default: begin va = v2; vb = v0; end
    endcase
    // bbox-relative coordinates; never negative because xmin/ymin are minima
    xa_l = $signed({2'b00, va.x} - {2'b00, xmin_q});
    ya_l = $signed({2'b00, va.y} - {2'b00, ymin_q});
    xb_l = $signed({2'b00, vb.x} - {2'b00, xmin_q});
    yb_l = $signed({2'b00, vb.y} - {2'b00, ymin_q});
  end

  bresenham_stepper u_stepper (
    .clk      (clk),
    .init_i   (state_q == EDGE_INIT),
    .step_i   (state_q == STEP),
    .xa_i     (xa_l),
    .ya_i     (ya_l),
    .xb_i     (xb_l),
    .yb_i     (yb_l),
    .x_o      (cur_x),
    .y_o      (cur_y),
    .at_end_o (at_end)
  );

  assign in_win  = (cur_x < LB_LIM) && (cur_y < LB_LIM);
  assign pix_idx = {cur_y[IDX_W-1:0], cur_x[IDX_W-1:0]};

  // vertex capture and bounding box: datapath, no reset
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && raster_start) begin
      coords_q <= coordinates;
    end
    if (state_q == SETUP) begin
      xmin_q <= min3(v0.x, v1.x, v2.x);
      ymin_q <= min3(v0.y, v1.y, v2.y);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clip_q  <= 1'b0;
      edge_q  <= 2'd0;
      lb_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (raster_start) begin
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          lb_q    <= '0;
          clip_q  <= 1'b0;
          edge_q  <= 2'd0;
          state_q <= EDGE_INIT;
        end
        EDGE_INIT: state_q <= STEP;
        STEP: begin
          if (in_win) lb_q[pix_idx] <= 1'b1;
          else        clip_q        <= 1'b1;
          if (at_end) begin
            if (edge_q == 2'd2) begin
              state_q <= DONE;
            end else begin
              edge_q  <= edge_q + 2'd1;
              state_q <= EDGE_INIT;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign raster_done = done_q;
  assign clipped     = clip_q;
  assign line_buffer = lb_q;

`ifdef EDGE_PIXEL_COUNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= 8'd0;
    end else if (state_q == SETUP) begin
      cnt_q <= 8'd0;
    end else if ((state_q == STEP) && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign pixel_count = cnt_q;
`endif

endmodule
